// File: rtl/rc_io_pkg.sv
// Shared definitions for the RC Z80 I/O peripherals: register map, CTRL/STATUS
// bit positions and the SPI sequencer states.
package rc_io_pkg;

    localparam logic [1:0] SPI_REG_DATA = 2'd0;
    localparam logic [1:0] SPI_REG_CTRL = 2'd1;
    localparam logic [1:0] SPI_REG_DIV  = 2'd2;

    localparam int CTRL_CS_EN_BIT = 0;
    localparam int CTRL_FAST_BIT  = 1;
    localparam int STAT_DONE_BIT  = 6;
    localparam int STAT_BUSY_BIT  = 7;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } spi_state_t;

endpackage

// File: rtl/spi_shift8.sv
// 8-bit SPI datapath: transmit register shifted MSB-first and receive register
// filled from MISO, both advancing on each SCK rise.
module spi_shift8 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] din_i,
    input  logic       shift_i,
    input  logic       miso_i,
    output logic       tx_msb_o,
    output logic [7:0] rx_o
);

    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;

    always_comb begin
        tx_d = tx_q;
        rx_d = rx_q;
        if (load_i) begin
            tx_d = din_i;
        end else if (shift_i) begin
            tx_d = {tx_q[6:0], 1'b0};
            rx_d = {rx_q[6:0], miso_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            tx_q <= tx_d;
            rx_q <= rx_d;
        end
    end

    // After a rise has shifted, the MSB already holds the bit for the next LOW phase.
    assign tx_msb_o = tx_q[7];
    assign rx_o     = rx_q;

endmodule

// File: rtl/z80_spi_master.sv
// Z80 I/O-mapped SPI master (mode 0) feeding the SD card: CPU register file,
// edge-detected access strobes, SCK half-period divider and bit sequencer.
module z80_spi_master
    import rc_io_pkg::*;
#(
    parameter logic [7:0] SLOW_DIV  = 8'd71,
    parameter logic [7:0] RESET_DIV = 8'd1
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       io_cs,
    input  logic [1:0] io_addr,
    input  logic       io_rd,
    input  logic       io_wr,
    input  logic [7:0] io_din,
    output logic [7:0] io_dout,
    output logic       sd_cs,
    output logic       sd_sck,
    output logic       sd_mosi,
    input  logic       sd_miso,
    output logic       busy
);

    spi_state_t state_q, state_d;
    logic [7:0] half_q, half_d;
    logic [7:0] hlim_q, hlim_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       cs_en_q, cs_en_d;
    logic       fast_q, fast_d;
    logic [7:0] div_q, div_d;
    logic       wr_prev_q, rd_prev_q;

    logic       wr_lvl, rd_lvl, wr_stb, rd_stb;
    logic       sh_load, sh_shift, sh_tx_msb;
    logic [7:0] sh_rx;
    logic [7:0] status;

    // Edge-detect the level strobes so a long CPU I/O cycle acts exactly once.
    assign wr_lvl = io_cs & io_wr;
    assign rd_lvl = io_cs & io_rd & (io_addr == SPI_REG_DATA);
    assign wr_stb = wr_lvl & ~wr_prev_q;
    assign rd_stb = ~rd_lvl & rd_prev_q;

    spi_shift8 u_shift (
        .clk_i    (clk_sys),
        .rst_i    (reset),
        .load_i   (sh_load),
        .din_i    (io_din),
        .shift_i  (sh_shift),
        .miso_i   (sd_miso),
        .tx_msb_o (sh_tx_msb),
        .rx_o     (sh_rx)
    );

    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        hlim_d    = hlim_q;
        bitcnt_d  = bitcnt_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = done_q;
        rx_data_d = rx_data_q;
        cs_en_d   = cs_en_q;
        fast_d    = fast_q;
        div_d     = div_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;

        if (wr_stb) begin
            case (io_addr)
                SPI_REG_CTRL: begin
                    cs_en_d = io_din[CTRL_CS_EN_BIT];
                    fast_d  = io_din[CTRL_FAST_BIT];
                end
                SPI_REG_DIV: div_d = io_din;
                default: ;
            endcase
        end
        if (rd_stb) done_d = 1'b0;

        // Completion is evaluated after the read-clear so that it wins a tie.
        case (state_q)
            IDLE: begin
                if (wr_stb && io_addr == SPI_REG_DATA) begin
                    sh_load  = 1'b1;
                    bitcnt_d = 3'd7;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    mosi_d   = io_din[7];
                    half_d   = '0;
                    hlim_d   = fast_q ? div_q : SLOW_DIV;
                    state_d  = LOW;
                end
            end
            LOW: begin
                if (half_q == hlim_q) begin
                    half_d   = '0;
                    sck_d    = 1'b1;
                    sh_shift = 1'b1;
                    state_d  = HIGH;
                end else begin
                    half_d = half_q + 8'd1;
                end
            end
            HIGH: begin
                if (half_q == hlim_q) begin
                    half_d = '0;
                    sck_d  = 1'b0;
                    if (bitcnt_q == 3'd0) begin
                        rx_data_d = sh_rx;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        mosi_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q - 3'd1;
                        mosi_d   = sh_tx_msb;
                        state_d  = LOW;
                    end
                end else begin
                    half_d = half_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            half_q    <= '0;
            hlim_q    <= '0;
            bitcnt_q  <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= 8'hFF;
            cs_en_q   <= 1'b0;
            fast_q    <= 1'b0;
            div_q     <= RESET_DIV;
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            hlim_q    <= hlim_d;
            bitcnt_q  <= bitcnt_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
            cs_en_q   <= cs_en_d;
            fast_q    <= fast_d;
            div_q     <= div_d;
            wr_prev_q <= wr_lvl;
            rd_prev_q <= rd_lvl;
        end
    end

    always_comb begin
        status                = '0;
        status[STAT_BUSY_BIT] = busy_q;
        status[STAT_DONE_BIT] = done_q;
        status[CTRL_FAST_BIT] = fast_q;
        status[CTRL_CS_EN_BIT] = cs_en_q;
    end

    always_comb begin
        io_dout = 8'hFF;
        if (io_cs && io_rd) begin
            case (io_addr)
                SPI_REG_DATA: io_dout = rx_data_q;
                SPI_REG_CTRL: io_dout = status;
                SPI_REG_DIV:  io_dout = div_q;
                default:      io_dout = 8'hFF;
            endcase
        end
    end

    assign sd_cs   = ~cs_en_q;
    assign sd_sck  = sck_q;
    assign sd_mosi = mosi_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_z80_spi_master.sv
// Bench for z80_spi_master: CPU bus tasks, an SPI slave model returning a chosen
// byte, and a negedge monitor logging every SCK rise with its MOSI bit and cycle.
module tb_z80_spi_master;
    import rc_io_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       io_cs   = 1'b0;
    logic [1:0] io_addr = 2'd0;
    logic       io_rd   = 1'b0;
    logic       io_wr   = 1'b0;
    logic [7:0] io_din  = 8'h00;
    logic [7:0] io_dout;
    logic       sd_cs, sd_sck, sd_mosi, sd_miso, busy;

    int errors = 0;
    int checks = 0;

    int         cyc   = 0;
    int         rises = 0;
    int         base  = 0;
    logic       sck_prev = 1'b0;
    logic       mosi_hist [0:1023];
    int         rise_cyc  [0:1023];
    logic [7:0] slave_byte = 8'hFF;

    z80_spi_master dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .io_cs   (io_cs),
        .io_addr (io_addr),
        .io_rd   (io_rd),
        .io_wr   (io_wr),
        .io_din  (io_din),
        .io_dout (io_dout),
        .sd_cs   (sd_cs),
        .sd_sck  (sd_sck),
        .sd_mosi (sd_mosi),
        .sd_miso (sd_miso),
        .busy    (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Slave presents bit (7-k) of its byte before the k-th rise of the current transfer.
    assign sd_miso = (rises - base >= 0 && rises - base < 8) ?
                     slave_byte[3'(7 - (rises - base))] : 1'b1;

    always @(negedge clk_sys) begin
        cyc      <= cyc + 1;
        sck_prev <= sd_sck;
        if (sd_sck && !sck_prev && rises < 1024) begin
            mosi_hist[rises] <= sd_mosi;
            rise_cyc[rises]  <= cyc;
            rises            <= rises + 1;
        end
    end

    task automatic io_write(input logic [1:0] a, input logic [7:0] d, input int len);
        @(negedge clk_sys);
        io_cs = 1'b1; io_wr = 1'b1; io_addr = a; io_din = d;
        repeat (len) @(negedge clk_sys);
        io_cs = 1'b0; io_wr = 1'b0;
    endtask

    task automatic io_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk_sys);
        io_cs = 1'b1; io_rd = 1'b1; io_addr = a;
        #1 d = io_dout;
        @(negedge clk_sys);
        io_cs = 1'b0; io_rd = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk_sys);
        end
    endtask

    // Reference: MOSI must carry tx MSB-first, one bit per rise of this transfer.
    function automatic int mosi_bad(input logic [7:0] tx);
        int bad = 0;
        for (int i = 0; i < 8; i++)
            if (mosi_hist[base + i] !== tx[7 - i]) bad++;
        return bad;
    endfunction

    function automatic int gap_bad(input int h);
        int bad = 0;
        for (int i = 1; i < 8; i++)
            if (rise_cyc[base + i] - rise_cyc[base + i - 1] != 2 * h) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        checks++; if ({sd_cs, sd_sck, sd_mosi, busy} !== 4'b1010) begin errors++;
            $display("FAIL reset_pins cs/sck/mosi/busy=%b want 1010", {sd_cs, sd_sck, sd_mosi, busy}); end
        checks++; if (io_dout !== 8'hFF) begin errors++;
            $display("FAIL reset_idle_dout got %h want ff", io_dout); end
        io_read(SPI_REG_CTRL, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", v); end
        io_read(SPI_REG_DIV, v);
        checks++; if (v !== 8'h01) begin errors++; $display("FAIL reset_div got %h want 01", v); end
        io_read(SPI_REG_DATA, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL reset_data got %h want ff", v); end
        io_read(2'd3, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL reset_addr3 got %h want ff", v); end
    endtask

    task automatic test_fast_xfer();
        logic [7:0] v;
        int n;
        io_write(SPI_REG_CTRL, 8'h03, 1);
        io_write(SPI_REG_DIV, 8'h00, 1);
        base = rises; slave_byte = 8'h3C;
        io_write(SPI_REG_DATA, 8'hA5, 1);
        wait_idle(n);
        repeat (2) @(negedge clk_sys);
        checks++; if (n != 16) begin errors++; $display("FAIL fast_busy_len got %0d want 16", n); end
        checks++; if (mosi_bad(8'hA5) != 0) begin errors++;
            $display("FAIL fast_mosi bad_bits=%0d want 0", mosi_bad(8'hA5)); end
        checks++; if (gap_bad(1) != 0) begin errors++; $display("FAIL fast_gaps bad=%0d want 0", gap_bad(1)); end
        io_read(SPI_REG_CTRL, v);
        checks++; if (v !== 8'h43) begin errors++; $display("FAIL fast_status_pre got %h want 43", v); end
        io_read(SPI_REG_DATA, v);
        checks++; if (v !== 8'h3C) begin errors++; $display("FAIL fast_rx got %h want 3c", v); end
        io_read(SPI_REG_CTRL, v);
        checks++; if (v !== 8'h03) begin errors++; $display("FAIL fast_status_post got %h want 03", v); end
    endtask

    task automatic test_slow_xfer();
        logic [7:0] v;
        int n = 0, cs_hi = 0;
        io_write(SPI_REG_CTRL, 8'h01, 1);
        base = rises; slave_byte = 8'h5A;
        io_write(SPI_REG_DATA, 8'hFF, 1);
        while (busy && n < 5000) begin
            if (sd_cs) cs_hi++;
            n++;
            @(negedge clk_sys);
        end
        repeat (2) @(negedge clk_sys);
        checks++; if (n != 1152) begin errors++; $display("FAIL slow_busy_len got %0d want 1152", n); end
        checks++; if (cs_hi != 0) begin errors++; $display("FAIL slow_cs_low cs_high_cycles=%0d want 0", cs_hi); end
        checks++; if (gap_bad(72) != 0) begin errors++; $display("FAIL slow_gaps bad=%0d want 0", gap_bad(72)); end
        io_read(SPI_REG_DATA, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL slow_rx got %h want 5a", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        int n;
        io_write(SPI_REG_CTRL, 8'h03, 1);
        io_write(SPI_REG_DIV, 8'h02, 1);
        base = rises; slave_byte = 8'h96;
        io_write(SPI_REG_DATA, 8'h81, 1);
        repeat (3) @(negedge clk_sys);
        io_write(SPI_REG_DATA, 8'h00, 1);
        wait_idle(n);
        repeat (30) @(negedge clk_sys);
        checks++; if (rises - base != 8) begin errors++; $display("FAIL b2b_rises got %0d want 8", rises - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_restart busy=%b want 0", busy); end
        checks++; if (mosi_bad(8'h81) != 0) begin errors++; $display("FAIL b2b_mosi bad_bits=%0d want 0", mosi_bad(8'h81)); end
        io_read(SPI_REG_DATA, v);
        checks++; if (v !== 8'h96) begin errors++; $display("FAIL b2b_rx got %h want 96", v); end
    endtask

    task automatic test_long_wr_div();
        logic [7:0] v;
        int n;
        base = rises; slave_byte = 8'h27;
        io_write(SPI_REG_DATA, 8'hC3, 40);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL long_still_busy busy=%b want 1", busy); end
        io_write(SPI_REG_DIV, 8'h04, 1);
        wait_idle(n);
        repeat (20) @(negedge clk_sys);
        checks++; if (rises - base != 8) begin errors++; $display("FAIL long_rises got %0d want 8", rises - base); end
        checks++; if (gap_bad(3) != 0) begin errors++; $display("FAIL long_keep_h bad=%0d want 0", gap_bad(3)); end
        checks++; if (mosi_bad(8'hC3) != 0) begin errors++; $display("FAIL long_mosi bad_bits=%0d want 0", mosi_bad(8'hC3)); end
        io_read(SPI_REG_DIV, v);
        checks++; if (v !== 8'h04) begin errors++; $display("FAIL long_div_rb got %h want 04", v); end
        base = rises; slave_byte = 8'hE1;
        io_write(SPI_REG_DATA, 8'h3C, 1);
        wait_idle(n);
        repeat (2) @(negedge clk_sys);
        checks++; if (n != 80) begin errors++; $display("FAIL next_busy_len got %0d want 80", n); end
        checks++; if (gap_bad(5) != 0) begin errors++; $display("FAIL next_gaps bad=%0d want 0", gap_bad(5)); end
    endtask

    task automatic test_done_race();
        logic [7:0] v;
        io_write(SPI_REG_DIV, 8'h00, 1);
        base = rises; slave_byte = 8'h11;
        io_write(SPI_REG_DATA, 8'h42, 1);
        repeat (13) @(negedge clk_sys);
        io_read(SPI_REG_DATA, v);
        io_read(SPI_REG_CTRL, v);
        checks++; if (v !== 8'h43) begin errors++; $display("FAIL race_done got %h want 43", v); end
        io_read(SPI_REG_DATA, v);
        checks++; if (v !== 8'h11) begin errors++; $display("FAIL race_rx got %h want 11", v); end
    endtask

    task automatic test_random();
        logic [7:0] v, tx, sl, dv;
        int n;
        for (int it = 0; it < 10; it++) begin
            dv = 8'($urandom_range(0, 3));
            tx = 8'($urandom);
            sl = 8'($urandom);
            io_write(SPI_REG_DIV, dv, 1);
            base = rises; slave_byte = sl;
            io_write(SPI_REG_DATA, tx, 1);
            wait_idle(n);
            repeat (2) @(negedge clk_sys);
            checks++; if (n != 16 * (int'(dv) + 1)) begin errors++;
                $display("FAIL rnd_busy_len it=%0d got %0d want %0d", it, n, 16 * (int'(dv) + 1)); end
            checks++; if (mosi_bad(tx) != 0 || gap_bad(int'(dv) + 1) != 0) begin errors++;
                $display("FAIL rnd_wave it=%0d tx=%h mosi_bad=%0d gap_bad=%0d want 0/0", it, tx, mosi_bad(tx), gap_bad(int'(dv) + 1)); end
            io_read(SPI_REG_DATA, v);
            checks++; if (v !== sl) begin errors++; $display("FAIL rnd_rx it=%0d got %h want %h", it, v, sl); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int n = 0;
        io_write(SPI_REG_CTRL, 8'h03, 1);
        io_write(SPI_REG_DIV, 8'h02, 1);
        base = rises; slave_byte = 8'h00;
        io_write(SPI_REG_DATA, 8'h5A, 1);
        while (rises - base < 4 && n < 500) begin
            n++;
            @(negedge clk_sys);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre busy=%b want 1", busy); end
        reset = 1'b1;
        @(negedge clk_sys);
        checks++; if ({sd_sck, busy, sd_mosi, sd_cs} !== 4'b0011) begin errors++;
            $display("FAIL rstmid_pins sck/busy/mosi/cs=%b want 0011", {sd_sck, busy, sd_mosi, sd_cs}); end
        reset = 1'b0;
        io_read(SPI_REG_DATA, v);
        checks++; if (v !== 8'hFF) begin errors++; $display("FAIL rstmid_rx got %h want ff", v); end
        io_read(SPI_REG_CTRL, v);
        checks++; if (v !== 8'h00) begin errors++; $display("FAIL rstmid_ctrl got %h want 00", v); end
    endtask

    initial begin
        test_reset();
        test_fast_xfer();
        test_slow_xfer();
        test_back_to_back();
        test_long_wr_div();
        test_done_race();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
